stage_controller_multi_region: RTL



---
 rtl/stage_controller_multi_region_pkg.sv | 15 +
 rtl/stage_controller_multi_region_status.sv | 24 ++
 rtl/stage_controller_multi_region.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stage_controller_multi_region_pkg.sv
// Shared stage codes broadcast from the global controller to every PE region.
package stage_controller_multi_region_pkg;

    localparam int unsigned STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE         = 3'd0,
        STAGE_GROW         = 3'd1,
        STAGE_MERGE        = 3'd2,
        STAGE_LOADING      = 3'd3,
        STAGE_PEELING      = 3'd4,
        STAGE_RESULT_VALID = 3'd5
    } stage_t;

endpackage

// File: rtl/stage_controller_multi_region_status.sv
// Masks, OR-reduces and registers the per-region busy and odd-cluster flags.
module region_status_aggregator #(
    parameter int unsigned NUM_REGIONS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REGIONS-1:0] region_enable,
    input  logic [NUM_REGIONS-1:0] busy_region,
    input  logic [NUM_REGIONS-1:0] odd_clusters_region,
    output logic                   busy,
    output logic                   odd
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            odd  <= 1'b0;
        end else begin
            busy <= |(busy_region & region_enable);
            odd  <= |(odd_clusters_region & region_enable);
        end
    end

endmodule

// File: rtl/stage_controller_multi_region.sv
// Global round sequencer: loading, grow/merge iterations, peeling and result hand-off.
module stage_controller_multi_region
    import stage_controller_multi_region_pkg::*;
#(
    parameter int unsigned NUM_REGIONS             = 4,
    parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
    parameter int unsigned MAX_ITERATIONS          = 255,
    parameter int unsigned MAXIMUM_DELAY           = 3,
    parameter int unsigned CYCLE_COUNTER_WIDTH     = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   new_round_start,
    input  logic [NUM_REGIONS-1:0]                 region_enable,
    input  logic [NUM_REGIONS-1:0]                 busy_region,
    input  logic [NUM_REGIONS-1:0]                 odd_clusters_region,
    input  logic [$clog2(MAXIMUM_DELAY+1)-1:0]     merge_delay,
    input  logic                                   peel_busy,
    input  logic                                   result_ready,
    output logic [STAGE_WIDTH-1:0]                 global_stage,
    output logic                                   result_valid,
    output logic                                   result_timeout,
    output logic [ITERATION_COUNTER_WIDTH-1:0]     iteration_counter,
    output logic [CYCLE_COUNTER_WIDTH-1:0]         cycle_counter
);

    localparam int unsigned DELAY_WIDTH = $clog2(MAXIMUM_DELAY + 1);
    localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(MAXIMUM_DELAY);
    localparam logic [ITERATION_COUNTER_WIDTH-1:0] ITER_LIMIT =
        ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS);

    stage_t                 stage;
    logic                   busy;
    logic                   odd;
    logic [DELAY_WIDTH-1:0] delay_counter;
    logic [DELAY_WIDTH-1:0] delay_limit;
    logic [DELAY_WIDTH-1:0] delay_eff_c;

    region_status_aggregator #(
        .NUM_REGIONS (NUM_REGIONS)
    ) u_status (
        .clk                 (clk),
        .reset               (reset),
        .region_enable       (region_enable),
        .busy_region         (busy_region),
        .odd_clusters_region (odd_clusters_region),
        .busy                (busy),
        .odd                 (odd)
    );

    assign global_stage = stage;

    // Settle delay clamped to [1, MAXIMUM_DELAY]; compared wide so the clamp survives any width.
    always_comb begin
        delay_eff_c = merge_delay;
        if (merge_delay == '0) begin
            delay_eff_c = DELAY_WIDTH'(1);
        end else if (32'(merge_delay) > 32'(MAXIMUM_DELAY)) begin
            delay_eff_c = DELAY_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage             <= STAGE_IDLE;
            result_valid      <= 1'b0;
            result_timeout    <= 1'b0;
            iteration_counter <= '0;
            cycle_counter     <= '0;
            delay_counter     <= '0;
            delay_limit       <= '0;
        end else begin
            if ((stage inside {STAGE_LOADING, STAGE_GROW, STAGE_MERGE, STAGE_PEELING}) &&
                (cycle_counter != '1)) begin
                cycle_counter <= cycle_counter + CYCLE_COUNTER_WIDTH'(1);
            end

            case (stage)
                STAGE_IDLE: begin
                    if (new_round_start) begin
                        stage             <= STAGE_LOADING;
                        iteration_counter <= '0;
                        cycle_counter     <= '0;
                        result_timeout    <= 1'b0;
                    end
                end
                STAGE_LOADING: begin
                    stage             <= STAGE_GROW;
                    iteration_counter <= iteration_counter + ITERATION_COUNTER_WIDTH'(1);
                end
                STAGE_GROW: begin
                    stage         <= STAGE_MERGE;
                    delay_counter <= '0;
                    delay_limit   <= delay_eff_c;
                end
                STAGE_MERGE: begin
                    // Settle first, then wait out busy before judging odd clusters.
                    if (delay_counter < delay_limit) begin
                        delay_counter <= delay_counter + DELAY_WIDTH'(1);
                    end else if (!busy) begin
                        if (!odd) begin
                            stage <= STAGE_PEELING;
                        end else if (iteration_counter < ITER_LIMIT) begin
                            stage             <= STAGE_GROW;
                            iteration_counter <= iteration_counter + ITERATION_COUNTER_WIDTH'(1);
                        end else begin
                            stage          <= STAGE_RESULT_VALID;
                            result_valid   <= 1'b1;
                            result_timeout <= 1'b1;
                        end
                    end
                end
                STAGE_PEELING: begin
                    if (!peel_busy) begin
                        stage        <= STAGE_RESULT_VALID;
                        result_valid <= 1'b1;
                    end
                end
                STAGE_RESULT_VALID: begin
                    if (result_ready) begin
                        stage        <= STAGE_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    stage        <= STAGE_IDLE;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
